// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and
// the bit-counter width helper.
package serial_adder_pkg;

  // Encoding 2'd3 is unreachable and is decoded as IDLE.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } sa_state_e;

  // Counter must hold 0..WIDTH.
  function automatic int sa_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/structuralFullAdder.sv
// One-bit full adder cell; the only carry logic in the serial adder.
module structuralFullAdder (
  output logic sum,
  output logic carryout,
  input  logic a,
  input  logic b,
  input  logic carryin
);

  logic axb;

  assign axb      = a ^ b;
  assign sum      = axb ^ carryin;
  assign carryout = (a & b) | (axb & carryin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: accepts operands on a valid/ready handshake,
// feeds one bit pair per cycle LSB-first through a single full adder and
// presents {carryout,sum} on a second valid/ready handshake.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             busy
);

  localparam int CW = sa_cnt_w(WIDTH);

  sa_state_e        state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic fa_sum, fa_co;

  structuralFullAdder u_fa (
    .sum      (fa_sum),
    .carryout (fa_co),
    .a        (a_sh_q[0]),
    .b        (b_sh_q[0]),
    .carryin  (carry_q)
  );

  // Registered result: sum/carryout hold until the next op starts shifting.
  assign sum      = sum_sh_q;
  assign carryout = carry_q;

  // State and datapath registers; reset abandons any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state, datapath update and handshake outputs.
  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    sum_sh_d  = sum_sh_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      S_SHIFT: begin
        busy     = 1'b1;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
        sum_sh_d = (sum_sh_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
        carry_d  = fa_co;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: begin
        // S_IDLE and the unreachable 2'd3 encoding.
        in_ready = 1'b1;
        state_d  = S_IDLE;
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = carryin;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
    endcase
  end

endmodule
